// File: rtl/pivot_row_m_axis_streamer.sv
// AXI4-Stream master: streams num_words consecutive buffer words starting at base_addr
// as one packet, using a 2-entry skid buffer to hide the 1-cycle buffer read latency.
module pivot_row_m_axis_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    halt,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]    num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  rd_ptr;
    logic [LEN_WIDTH-1:0]  tx_cnt;
    logic [LEN_WIDTH-1:0]  last_idx;
    logic                  inflight;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] mem [0:1];
    logic                  wr_idx;
    logic                  rd_idx;
    logic [1:0]            occ;

    logic                  pop;
    logic                  last_pop;
    logic [2:0]            level;
    logic                  room;

    // Slots committed once this cycle's pop retires: buffered words plus the read in flight.
    assign level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign room     = (level < 3'd2);
    assign last_idx = len_q - LEN_WIDTH'(1);

    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = mem[rd_idx];
    assign m_axis_tstrb  = {(DATA_WIDTH/8){m_axis_tvalid}};
    assign m_axis_tlast  = m_axis_tvalid && (tx_cnt == last_idx);

    assign pop      = m_axis_tvalid && m_axis_tready;
    assign last_pop = pop && m_axis_tlast;

    assign busy    = (state == STREAM);
    assign done    = done_q;
    assign rd_en   = (state == STREAM) && !halt && (rd_ptr < len_q) && room;
    assign rd_addr = base_q + ADDR_WIDTH'(rd_ptr);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (num_words != '0)) state_nxt = STREAM;
            STREAM:  if (halt || last_pop)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            base_q   <= '0;
            len_q    <= '0;
            rd_ptr   <= '0;
            tx_cnt   <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            occ      <= '0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (num_words != '0) begin
                        base_q <= base_addr;
                        len_q  <= num_words;
                        rd_ptr <= '0;
                        tx_cnt <= '0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
            end else if (halt) begin
                // Abort: drop buffered words and the outstanding read; no tlast, no done.
                inflight <= 1'b0;
                occ      <= '0;
                wr_idx   <= 1'b0;
                rd_idx   <= 1'b0;
            end else begin
                inflight <= rd_en;
                if (rd_en) rd_ptr <= rd_ptr + LEN_WIDTH'(1);
                if (inflight) begin
                    mem[wr_idx] <= rd_data;
                    wr_idx      <= ~wr_idx;
                end
                if (pop) begin
                    rd_idx <= ~rd_idx;
                    tx_cnt <= tx_cnt + LEN_WIDTH'(1);
                end
                occ <= occ + {1'b0, inflight} - {1'b0, pop};
                if (last_pop) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pivot_row_m_axis_streamer.sv
// Bench for pivot_row_m_axis_streamer: table of packets plus random packets, each checked
// against an expected word list derived from base/length, plus reset and halt sequences.
module tb_pivot_row_m_axis_streamer;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LW = 10;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] num_words = '0;
    logic          busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic          m_axis_tlast, m_axis_tvalid;
    logic          m_axis_tready = 1'b0;

    pivot_row_m_axis_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .aclk(aclk), .areset(areset), .start(start), .halt(halt),
        .base_addr(base_addr), .num_words(num_words), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic [DW-1:0] salt = 32'h0000_0100;

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return 32'(a) + salt;
    endfunction

    // Synchronous-read buffer model
    always @(posedge aclk) if (rd_en) rd_data <= word_at(rd_addr);

    // Monitor: records what the DUT did, sampled mid-cycle.
    bit            mon_en = 0;
    int            t0 = 0;
    logic [AW-1:0] rd_q[$];
    int            rd_cyc_q[$];
    logic [DW-1:0] beat_q[$];
    bit            last_q[$];
    int            beat_cyc_q[$];
    int            issued, popped, max_out, done_cnt, done_cyc;
    int            stall_viol, strb_viol, halt_rd_viol, tlast_cnt;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic mon_clear();
        rd_q.delete(); rd_cyc_q.delete(); beat_q.delete(); last_q.delete(); beat_cyc_q.delete();
        issued = 0; popped = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
        stall_viol = 0; strb_viol = 0; halt_rd_viol = 0; tlast_cnt = 0; prev_stall = 0;
    endtask

    always @(negedge aclk) begin
        if (mon_en) begin
            if (rd_en) begin
                rd_q.push_back(rd_addr);
                rd_cyc_q.push_back(cyc - t0);
                issued++;
                if (halt) halt_rd_viol++;
            end
            if (m_axis_tvalid) begin
                if (prev_stall && (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
                    stall_viol++;
                if (m_axis_tstrb !== {(DW/8){1'b1}}) strb_viol++;
                if (m_axis_tlast) tlast_cnt++;
                if (m_axis_tready) begin
                    beat_q.push_back(m_axis_tdata);
                    last_q.push_back(m_axis_tlast);
                    beat_cyc_q.push_back(cyc - t0);
                    popped++;
                end
            end else if (prev_stall) begin
                stall_viol++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc - t0;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            mode;
        int            halt_at;
        int            restart_at;
    } vec_t;

    int halt_k;

    // Runs one packet; returns after done (or halt) plus a few idle cycles, bounded.
    task automatic run_pkt(input vec_t v);
        bit finished = 0;
        bit halted   = 0;
        int done_k   = -1;
        mon_clear();
        halt_k = -1;
        @(posedge aclk); #1;
        base_addr = v.base; num_words = v.len; start = 1'b1;
        m_axis_tready = rdy(v.mode, 0);
        t0 = cyc; mon_en = 1;
        for (int k = 1; k < 600; k++) begin
            @(posedge aclk); #1;
            start = 1'b0;
            halt  = 1'b0;
            m_axis_tready = rdy(v.mode, k);
            if (halted && k == halt_k + 1) begin
                check("halt_tvalid_low", m_axis_tvalid, 0);
                check("halt_busy_low", busy, 0);
            end
            if (k == v.restart_at) begin
                start = 1'b1; base_addr = v.base + 12'h123; num_words = v.len + 10'd3;
            end
            if (v.halt_at >= 0 && !halted && popped >= v.halt_at) begin
                halt = 1'b1; halted = 1; halt_k = k;
            end
            if (done_cnt > 0 && done_k < 0) done_k = k;
            if ((done_k >= 0 && k >= done_k + 3) || (halted && k >= halt_k + 4)) begin
                finished = 1;
                break;
            end
        end
        mon_en = 0;
        start = 1'b0; halt = 1'b0;
        check("pkt_completed", finished, 1);
    endtask

    task automatic check_pkt(input vec_t v);
        int n = int'(v.len);
        logic [AW-1:0] a;
        if (v.halt_at < 0) begin
            check("beat_count", beat_q.size(), n);
            check("read_count", rd_q.size(), n);
            check("done_count", done_cnt, 1);
            for (int i = 0; i < n && i < beat_q.size(); i++) begin
                a = v.base + AW'(i);
                check("beat_data", beat_q[i], word_at(a));
                check("beat_last", last_q[i], (i == n - 1));
            end
            for (int i = 0; i < n && i < rd_q.size(); i++) begin
                a = v.base + AW'(i);
                check("rd_addr", rd_q[i], a);
            end
            if (v.mode == 0) begin
                check("done_cycle", done_cyc, (n == 0) ? 1 : n + 3);
                for (int i = 0; i < n && i < beat_cyc_q.size(); i++) begin
                    check("beat_cycle", beat_cyc_q[i], 3 + i);
                    check("rd_cycle", rd_cyc_q[i], 1 + i);
                end
            end
        end else begin
            check("halt_no_done", done_cnt, 0);
            check("halt_no_tlast", tlast_cnt, 0);
            check("halt_no_rd", halt_rd_viol, 0);
            check("halt_truncated", beat_q.size() < n, 1);
            for (int i = 0; i < beat_q.size(); i++) begin
                a = v.base + AW'(i);
                check("halt_beat_data", beat_q[i], word_at(a));
            end
        end
        check("stall_stable", stall_viol, 0);
        check("tstrb_ones", strb_viol, 0);
        check("occupancy_le2", max_out <= 2, 1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_rd_en"}, rd_en, 0);
        check({nm, "_rd_addr"}, rd_addr, 0);
        check({nm, "_tvalid"}, m_axis_tvalid, 0);
        check({nm, "_tlast"}, m_axis_tlast, 0);
        check({nm, "_tstrb"}, m_axis_tstrb, 0);
        check({nm, "_tdata"}, m_axis_tdata, 0);
    endtask

    vec_t tbl[8];
    vec_t v;
    bit   reached;

    initial begin
        tbl[0] = '{base: 12'h010, len: 10'd4,  mode: 0, halt_at: -1, restart_at: -1};
        tbl[1] = '{base: 12'h020, len: 10'd8,  mode: 1, halt_at: -1, restart_at: -1};
        tbl[2] = '{base: 12'h030, len: 10'd1,  mode: 0, halt_at: -1, restart_at: -1};
        tbl[3] = '{base: 12'h040, len: 10'd0,  mode: 0, halt_at: -1, restart_at: -1};
        tbl[4] = '{base: 12'hFFE, len: 10'd4,  mode: 0, halt_at: -1, restart_at: -1};
        tbl[5] = '{base: 12'h100, len: 10'd10, mode: 0, halt_at: 3,  restart_at: -1};
        tbl[6] = '{base: 12'h200, len: 10'd6,  mode: 2, halt_at: -1, restart_at: -1};
        tbl[7] = '{base: 12'h400, len: 10'd8,  mode: 0, halt_at: -1, restart_at: 3};

        #2;
        check_all_zero("reset");
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_pkt(tbl[i]);
            check_pkt(tbl[i]);
        end

        // Restart after halt
        v = '{base: 12'h180, len: 10'd5, mode: 0, halt_at: -1, restart_at: -1};
        run_pkt(v);
        check_pkt(v);

        // Asynchronous reset mid-packet, then a clean packet
        mon_clear();
        @(posedge aclk); #1;
        base_addr = 12'h300; num_words = 10'd10; start = 1'b1; m_axis_tready = 1'b1;
        t0 = cyc; mon_en = 1;
        @(posedge aclk); #1 start = 1'b0;
        reached = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge aclk); #1;
            if (popped >= 5) begin reached = 1; break; end
        end
        mon_en = 0;
        check("reset_mid_reached", reached, 1);
        #2 areset = 1'b1;
        #1 check_all_zero("async_reset");
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        v = '{base: 12'h300, len: 10'd10, mode: 0, halt_at: -1, restart_at: -1};
        run_pkt(v);
        check_pkt(v);

        // Randomized packets against the word-list model
        for (int r = 0; r < 8; r++) begin
            salt = $urandom;
            v.base = AW'($urandom);
            v.len = LW'($urandom_range(1, 20));
            v.mode = int'($urandom_range(0, 2));
            v.halt_at = -1;
            v.restart_at = -1;
            run_pkt(v);
            check_pkt(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pivot_row_m_axis_streamer.md
Name: pivot_row_m_axis_streamer

Overview:
- AXI4-Stream master that reads a contiguous run of tableau words from a local synchronous-read buffer and transmits them as one packet, with tlast on the final word.
- Transmit counterpart of the pivot-row slave stream interfaces. It emits the selected pivot row or pivot column to the row/column update engines and to the DMA.
- A 2-entry output buffer absorbs the 1-cycle read latency, so the block sustains 1 beat/cycle under continuous tready.

Parameters:
- DATA_WIDTH, 32, stream and buffer data width (multiple of 8).
- ADDR_WIDTH, 12, buffer word-address width.
- LEN_WIDTH, 10, width of the word-count input.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- halt  in  1  abort request; acts in STREAM.
- base_addr  in  ADDR_WIDTH  first word address; latched on accepted start.
- num_words  in  LEN_WIDTH  packet length in words; latched on accepted start.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the tlast beat handshakes.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_WIDTH  buffer read address.
- rd_data  in  DATA_WIDTH  read data, valid the cycle after rd_en.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tstrb  out  DATA_WIDTH/8  byte strobes, always all ones when tvalid is high.
- m_axis_tlast  out  1  high on the last word of the packet.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; counters 0; output buffer emptied; in-flight flag cleared.
- FSM IDLE:
  - start=1 with num_words>0: latch base_addr and num_words, set rd_ptr=0 and tx_cnt=0, go to STREAM.
  - start=1 with num_words=0: stay in IDLE and pulse done in the next cycle. No beats and no reads.
- FSM STREAM, read issue:
  - rd_en=1 when rd_ptr<num_words, halt=0, and (occupancy + inflight − pop) < 2.
  - rd_addr = base_addr + rd_ptr, truncated to ADDR_WIDTH so it wraps modulo 2^ADDR_WIDTH. rd_ptr increments on each issue.
  - pop = m_axis_tvalid & m_axis_tready.
- FSM STREAM, buffering and output:
  - rd_data is written into the buffer in the cycle after rd_en.
  - The buffer head drives m_axis_tdata and m_axis_tvalid = (occupancy>0).
  - m_axis_tlast = tvalid & (tx_cnt == num_words−1).
  - tx_cnt increments on each pop.
  - A simultaneous write and pop in the same cycle is legal and leaves occupancy unchanged.
- Return to IDLE: on a pop with tlast=1, busy drops and done=1 for exactly the next cycle.
- AXIS rule: while tvalid=1 and tready=0, tdata, tlast and tvalid are held stable.
- Latency: start in cycle 0 → rd_en in cycle 1 → first tvalid in cycle 3. With tready held high, beats run in consecutive cycles.
- halt in STREAM:
  - No further rd_en from that cycle.
  - Next cycle: buffer flushed, any in-flight read discarded, tvalid=0, state=IDLE. No done pulse, and the truncated packet carries no tlast.
  - halt has no effect in IDLE.
- start while busy is ignored; the latched base and length are unchanged.
- Occupancy never exceeds 2. No read is issued beyond num_words.

Test Plan:
- base_addr=0x010, num_words=4, tready=1, buffer word at a = a+0x100:
  - rd_addr is 0x010..0x013 in cycles 1-4.
  - tdata is 0x110..0x113 in cycles 3-6, with tlast only in cycle 6.
  - done is high in cycle 7.
- num_words=8, tready toggling 1,0,0,1,…:
  - exactly 8 beats, in order, with no duplicates or drops.
  - tdata held stable on every stalled cycle.
  - occupancy ≤2 throughout; tlast on the 8th beat only.
- num_words=1 → a single beat with tlast=1, then done. num_words=0 → done pulse in cycle 1, tvalid never high, rd_en never high.
- base_addr=0xFFE, num_words=4 → rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- halt asserted after beat 3 of 10 → no rd_en from the halt cycle; tvalid=0 on the next cycle; busy=0; no done; no tlast seen. A following start works normally.
- areset asserted mid-packet (beat 5 of 10) → all outputs 0 immediately, without waiting for a clock edge. Releasing areset and then pulsing start gives a clean full packet.
- start re-pulsed while busy with a different base_addr → ignored; the original packet completes unchanged.
